// File: rtl/result_readout_if.sv
// Result handshake between the multiplier result source and the readout block.
interface result_readout_if;
  logic        result_valid;
  logic [31:0] dataR;
  logic        result_ready;

  // Producer side: offers a result word and watches for acceptance.
  modport master (
    output result_valid,
    output dataR,
    input  result_ready
  );

  // Consumer side: the readout block captures the word when ready.
  modport slave (
    input  result_valid,
    input  dataR,
    output result_ready
  );
endinterface

// File: rtl/result_readout.sv
// Result readout: captures a 32-bit result word over a valid/ready handshake
// and shows it as two 16-bit halves on four active-low 7-segment digits.
// A debounced enter pushbutton steps IDLE -> SHOW_HI -> SHOW_LO -> IDLE.
module result_readout #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter,
  result_readout_if.slave  bus,
  output logic             show_high,
  output logic             readout_done,
  output logic [6:0]       disp3,
  output logic [6:0]       disp2,
  output logic [6:0]       disp1,
  output logic [6:0]       disp0
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]    SEG_OFF  = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHOW_HI = 2'd1,
    S_SHOW_LO = 2'd2
  } state_t;

  // Hex digit to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Enter conditioning state.
  logic          sync1_q, sync2_q;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_s;

  // FSM and output registers.
  state_t        state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic          ready_q, ready_d;
  logic          show_high_q, show_high_d;
  logic          done_q, done_d;
  logic [27:0]   disp_q, disp_d;

  // Debounce: count mismatch cycles; flip the accepted level after a full stable run.
  // press fires in the cycle the accepted level is about to rise, so the FSM
  // reacts on the same edge that updates the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    press_s = 1'b0;
    if (sync2_q != acc_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        acc_d   = sync2_q;
        press_s = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Next state, word capture and next output values (outputs follow next state).
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A press arriving together with a result is dropped: capture wins.
        if (bus.result_valid && ready_q) begin
          word_d  = bus.dataR;
          state_d = S_SHOW_HI;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHOW_HI: begin
        if (press_s) begin
          state_d = S_SHOW_LO;
        end else begin
          state_d = S_SHOW_HI;
        end
      end
      S_SHOW_LO: begin
        if (press_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SHOW_LO;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d     = (state_d == S_IDLE);
    show_high_d = (state_d == S_SHOW_HI);
    case (state_d)
      S_SHOW_HI: disp_d = {hex7(word_d[31:28]), hex7(word_d[27:24]),
                           hex7(word_d[23:20]), hex7(word_d[19:16])};
      S_SHOW_LO: disp_d = {hex7(word_d[15:12]), hex7(word_d[11:8]),
                           hex7(word_d[7:4]),   hex7(word_d[3:0])};
      default:   disp_d = {4{SEG_OFF}};
    endcase
  end

  // All state and output registers; reset returns everything to the blank IDLE view.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      word_q      <= 32'h0000_0000;
      ready_q     <= 1'b1;
      show_high_q <= 1'b0;
      done_q      <= 1'b0;
      disp_q      <= {4{SEG_OFF}};
    end else begin
      sync1_q     <= enter;
      sync2_q     <= sync1_q;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      word_q      <= word_d;
      ready_q     <= ready_d;
      show_high_q <= show_high_d;
      done_q      <= done_d;
      disp_q      <= disp_d;
    end
  end

  assign bus.result_ready = ready_q;
  assign show_high        = show_high_q;
  assign readout_done     = done_q;
  assign disp3            = disp_q[27:21];
  assign disp2            = disp_q[20:14];
  assign disp1            = disp_q[13:7];
  assign disp0            = disp_q[6:0];

endmodule
